instr_cache: RTL and testbench

//  Direct-mapped instruction cache between instruction fetch (IF) and memory_controller.

---
 rtl/instr_cache_if.sv | 25 ++
 rtl/instr_cache.sv | 113 +++++++++++
 tb/tb_instr_cache.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_cache_if.sv
// Bus bundle between instruction fetch, instr_cache and memory_controller.
// The cache uses the slave modport; the fetch unit / controller side uses master.
interface instr_cache_if;
  // IF side: if_req is a level held until the one-cycle if_done pulse; a response
  // always belongs to the pc presented when the request was accepted.
  // Memory side: instr_signal/instr_a stay stable until the instr_done pulse.
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_done;
  logic [31:0] if_instr;
  logic        instr_signal;
  logic [31:0] instr_a;
  logic [63:0] instr_d;
  logic        instr_done;

  modport slave (
    input  if_req, if_pc, instr_d, instr_done,
    output if_done, if_instr, instr_signal, instr_a
  );

  modport master (
    output if_req, if_pc, instr_d, instr_done,
    input  if_done, if_instr, instr_signal, instr_a
  );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache, 64-bit lines, one-cycle hits.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module instr_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear_signal,
  instr_cache_if.slave bus,
`ifdef ICACHE_STATS_EN
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt,
`endif
  output logic         dbg_miss
);
  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 29 - INDEX_BITS;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t                  state;
  logic [63:0]             data_mem [LINES];
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [LINES-1:0]        valid;
  logic                    off_q;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [TAG_W-1:0]        fill_tag;
  logic [63:0]             req_line;
  logic                    hit;
  logic                    accept;
  logic                    fill;
  logic                    unused_bits;

  assign req_idx     = bus.if_pc[3 +: INDEX_BITS];
  assign req_tag     = bus.if_pc[31 -: TAG_W];
  // The outstanding line address doubles as the fill pointer.
  assign fill_idx    = bus.instr_a[3 +: INDEX_BITS];
  assign fill_tag    = bus.instr_a[31 -: TAG_W];
  assign req_line    = data_mem[req_idx];
  assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept      = (state == IDLE) && bus.if_req && !bus.if_done && !clear_signal;
  assign fill        = (state == MISS) && bus.instr_done;
  assign dbg_miss    = (state == MISS);
  assign unused_bits = ^{bus.if_pc[1:0], bus.instr_a[2:0]};

  // A response that coincides with a flush is still good data, so it is kept.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill) begin
      data_mem[fill_idx] <= bus.instr_d;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      valid            <= '0;
      off_q            <= 1'b0;
      bus.if_done      <= 1'b0;
      bus.if_instr     <= '0;
      bus.instr_signal <= 1'b0;
      bus.instr_a      <= '0;
`ifdef ICACHE_STATS_EN
      hit_cnt          <= '0;
      miss_cnt         <= '0;
`endif
    end else if (!rdy_in) begin
      bus.if_done <= 1'b0;
    end else if (clear_signal) begin
      bus.if_done      <= 1'b0;
      bus.instr_signal <= 1'b0;
      state            <= IDLE;
      if (fill) valid[fill_idx] <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.if_done <= 1'b0;
          if (accept) begin
            if (hit) begin
              bus.if_done  <= 1'b1;
              bus.if_instr <= bus.if_pc[2] ? req_line[63:32] : req_line[31:0];
`ifdef ICACHE_STATS_EN
              hit_cnt      <= hit_cnt + 32'd1;
`endif
            end else begin
              bus.instr_signal <= 1'b1;
              bus.instr_a      <= {bus.if_pc[31:3], 3'b000};
              off_q            <= bus.if_pc[2];
              state            <= MISS;
`ifdef ICACHE_STATS_EN
              miss_cnt         <= miss_cnt + 32'd1;
`endif
            end
          end
        end
        MISS: begin
          bus.if_done <= 1'b0;
          if (bus.instr_done) begin
            valid[fill_idx]  <= 1'b1;
            bus.if_done      <= 1'b1;
            bus.if_instr     <= off_q ? bus.instr_d[63:32] : bus.instr_d[31:0];
            bus.instr_signal <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: transaction-level cache model plus per-cycle compare.
// Build with ICACHE_STATS_EN defined to also check the hit/miss counters.
module tb_instr_cache;
  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic clear_signal;
  logic dbg_miss;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  instr_cache_if bus ();

  instr_cache dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_signal (clear_signal),
    .bus          (bus.slave),
`ifdef ICACHE_STATS_EN
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
`endif
    .dbg_miss     (dbg_miss)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // expected cycle-level behaviour, set by the drivers right after each edge
  logic        exp_done = 1'b0;
  logic        exp_sig  = 1'b0;
  logic [31:0] exp_a    = '0;
  logic        exp_busy = 1'b0;
  logic [31:0] exp_q[$];

  // cache contents at line granularity: which line address sits in each slot
  bit          m_valid [16];
  logic [31:0] m_line  [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_line(input logic [31:0] a);
    if (a == 32'h0) return 64'h00000013_00500093;
    return {a ^ 32'hdead_0000, a + 32'h0bad_0001};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    logic [63:0] d;
    d = mem_line({pc[31:3], 3'b000});
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 3) % 16);
    return m_valid[idx] && (m_line[idx] == {pc[31:3], 3'b000});
  endfunction

  function automatic void model_fill(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 3) % 16);
    m_valid[idx] = 1'b1;
    m_line[idx]  = {pc[31:3], 3'b000};
  endfunction

  // scoreboard compare, mid-cycle
  always @(negedge clk_in) begin
    if (rst_in) begin
      check("if_done", {63'd0, bus.if_done}, {63'd0, exp_done});
      check("instr_signal", {63'd0, bus.instr_signal}, {63'd0, exp_sig});
      check("state_miss", {63'd0, dbg_miss}, {63'd0, exp_busy});
      if (exp_sig) check("instr_a", {32'd0, bus.instr_a}, {32'd0, exp_a});
      if (exp_done) begin
        if (exp_q.size() == 0) check("exp_q_underflow", 64'd1, 64'd0);
        else check("if_instr", {32'd0, bus.if_instr}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // driver: one IF request; miss responses come resp_delay cycles after accept,
  // with rdy_in dropped for stall cycles first
  task automatic lookup(input logic [31:0] pc, input int resp_delay, input int stall,
                        output logic [31:0] got, output bit dut_hit);
    bit hit;
    hit = model_hit(pc);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    @(posedge clk_in); #1;
    dut_hit = !bus.instr_signal;
    if (hit) begin
      exp_done = 1'b1;
      exp_q.push_back(word_of(pc));
      got = bus.if_instr;
    end else begin
      exp_sig  = 1'b1;
      exp_a    = {pc[31:3], 3'b000};
      exp_busy = 1'b1;
      bus.if_pc = pc ^ 32'h0000_0108;
      if (stall > 0) begin
        rdy_in = 1'b0;
        repeat (stall) @(posedge clk_in);
        #1 rdy_in = 1'b1;
      end
      repeat (resp_delay) begin
        @(posedge clk_in); #1;
      end
      bus.instr_done = 1'b1;
      bus.instr_d    = mem_line({pc[31:3], 3'b000});
      @(posedge clk_in); #1;
      bus.instr_done = 1'b0;
      bus.instr_d    = '0;
      exp_sig  = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b1;
      exp_q.push_back(word_of(pc));
      model_fill(pc);
      got = bus.if_instr;
    end
    @(posedge clk_in); #1;
    bus.if_req = 1'b0;
    exp_done   = 1'b0;
    @(posedge clk_in); #1;
  endtask

  // driver: miss at pc, then flush after delay cycles, optionally with the response
  task automatic miss_clear(input logic [31:0] pc, input int delay, input bit with_done);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    @(posedge clk_in); #1;
    exp_sig  = 1'b1;
    exp_a    = {pc[31:3], 3'b000};
    exp_busy = 1'b1;
    repeat (delay - 1) begin
      @(posedge clk_in); #1;
    end
    clear_signal = 1'b1;
    if (with_done) begin
      bus.instr_done = 1'b1;
      bus.instr_d    = mem_line({pc[31:3], 3'b000});
    end
    @(posedge clk_in); #1;
    clear_signal   = 1'b0;
    bus.instr_done = 1'b0;
    bus.if_req     = 1'b0;
    exp_sig  = 1'b0;
    exp_busy = 1'b0;
    if (with_done) model_fill(pc);
    repeat (3) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic reset_mid_miss(input logic [31:0] pc);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    @(posedge clk_in); #1;
    exp_sig  = 1'b1;
    exp_a    = {pc[31:3], 3'b000};
    exp_busy = 1'b1;
    repeat (2) begin
      @(posedge clk_in); #1;
    end
    rst_in = 1'b0;
    #1;
    check("rst_instr_signal", {63'd0, bus.instr_signal}, 64'd0);
    check("rst_state", {63'd0, dbg_miss}, 64'd0);
    bus.if_req = 1'b0;
    exp_sig  = 1'b0;
    exp_busy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
  endtask

  logic [31:0] got;
  bit          hit;

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    clear_signal   = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_pc      = '0;
    bus.instr_d    = '0;
    bus.instr_done = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    check("reset_if_done", {63'd0, bus.if_done}, 64'd0);
    check("reset_if_instr", {32'd0, bus.if_instr}, 64'd0);
    check("reset_instr_signal", {63'd0, bus.instr_signal}, 64'd0);
    check("reset_instr_a", {32'd0, bus.instr_a}, 64'd0);
    @(posedge clk_in); #1;

    lookup(32'h0000_0000, 2, 0, got, hit);
    check("t1_word", {32'd0, got}, 64'h0000_0000_0050_0093);
    check("t1_miss", {63'd0, hit}, 64'd0);
    lookup(32'h0000_0004, 0, 0, got, hit);
    check("t2_word", {32'd0, got}, 64'h0000_0000_0000_0013);
    check("t2_hit", {63'd0, hit}, 64'd1);
    lookup(32'h0000_0080, 1, 0, got, hit);
    check("t3_word", {32'd0, got}, 64'h0000_0000_0bad_0081);
    check("t3_miss", {63'd0, hit}, 64'd0);
    lookup(32'h0000_0000, 3, 0, got, hit);
    check("t3_evict", {63'd0, hit}, 64'd0);
`ifdef ICACHE_STATS_EN
    check("hit_cnt", {32'd0, hit_cnt}, 64'd1);
    check("miss_cnt", {32'd0, miss_cnt}, 64'd3);
`endif

    miss_clear(32'h0000_0010, 3, 1'b0);
    lookup(32'h0000_0010, 1, 0, got, hit);
    check("t4_refetch", {63'd0, hit}, 64'd0);

    miss_clear(32'h0000_0020, 2, 1'b1);
    lookup(32'h0000_0024, 0, 0, got, hit);
    check("t5_hit", {63'd0, hit}, 64'd1);
    check("t5_word", {32'd0, got}, 64'h0000_0000_dead_0020);

    lookup(32'h0000_0034, 1, 5, got, hit);
    lookup(32'h0000_0030, 0, 0, got, hit);
    check("t6_hit", {63'd0, hit}, 64'd1);
    lookup(32'h1000_0088, 2, 0, got, hit);
    lookup(32'h0000_008c, 0, 0, got, hit);
    check("alias_evict", {63'd0, hit}, 64'd0);

    reset_mid_miss(32'h0000_0040);
    lookup(32'h0000_0004, 1, 0, got, hit);
    check("post_reset_miss", {63'd0, hit}, 64'd0);
    check("exp_q_drained", {32'd0, exp_q.size()}, 64'd0);

    repeat (2) @(posedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
